// File: rtl/dom_rand_gen.sv
// Fresh-randomness source for a DOM AND gadget: NUM_MASKS independent 31-bit
// Fibonacci LFSRs, serially seeded, warmed up, then released one step per
// accepted valid/ready handshake so no mask value is ever presented twice.
module dom_rand_gen #(
  parameter int unsigned NUM_SHARES    = 2,
  parameter int unsigned WARMUP_CYCLES = 64,
  localparam int unsigned NUM_MASKS    = (NUM_SHARES - 1) * NUM_SHARES / 2
) (
  input  logic                 ClkCI,
  input  logic                 RstRI,
  input  logic                 SeedStartSI,
  input  logic                 SeedValidSI,
  input  logic                 SeedDI,
  output logic [NUM_MASKS-1:0] RandomDO,
  output logic                 RandomValidSO,
  input  logic                 RandomReadySI,
  output logic                 BusySO
);

  localparam int unsigned LFSR_W     = 31;
  localparam int unsigned STATE_W    = NUM_MASKS * LFSR_W;
  localparam int unsigned BIT_CNT_W  = $clog2(STATE_W + 1);
  localparam int unsigned WARM_CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int unsigned WARM_LAST  = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StWarmup = 2'd2,
    StRun    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [STATE_W-1:0]    lfsr_q, lfsr_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WARM_CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  // Advance every LFSR by one step: fb = s[30] ^ s[27], shift left.
  function automatic logic [STATE_W-1:0] lfsr_step(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    logic [LFSR_W-1:0]  sm;
    r = s;
    for (int unsigned m = 0; m < NUM_MASKS; m++) begin
      sm = s[m*LFSR_W +: LFSR_W];
      r[m*LFSR_W +: LFSR_W] = {sm[LFSR_W-2:0], sm[30] ^ sm[27]};
    end
    return r;
  endfunction

  // An all-zero LFSR would lock up; force its LSB so it always runs.
  function automatic logic [STATE_W-1:0] zero_guard(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = s;
    for (int unsigned m = 0; m < NUM_MASKS; m++) begin
      if (s[m*LFSR_W +: LFSR_W] == '0) begin
        r[m*LFSR_W] = 1'b1;
      end
    end
    return r;
  endfunction

  // Mask bits come straight from the LFSR MSBs.
  for (genvar m = 0; m < NUM_MASKS; m++) begin : g_out
    assign RandomDO[m] = lfsr_q[m*LFSR_W + LFSR_W - 1];
  end

  assign RandomValidSO = valid_q;
  assign BusySO        = busy_q;

  // State, LFSR and counter registers.
  always_ff @(posedge ClkCI or negedge RstRI) begin
    if (!RstRI) begin
      state_q    <= StIdle;
      lfsr_q     <= '0;
      bit_cnt_q  <= '0;
      warm_cnt_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      bit_cnt_q  <= bit_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: seeding, warm-up stepping, handshake stepping, reseed override.
  always_comb begin
    logic [STATE_W-1:0] shifted;
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    bit_cnt_d  = bit_cnt_q;
    warm_cnt_d = warm_cnt_q;
    shifted    = {SeedDI, lfsr_q[STATE_W-1:1]};

    unique case (state_q)
      StIdle: ;
      StLoad: begin
        // A start pulse in the same cycle discards this seed bit.
        if (SeedValidSI && !SeedStartSI) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(STATE_W - 1)) begin
            lfsr_d     = zero_guard(shifted);
            warm_cnt_d = '0;
            state_d    = (WARMUP_CYCLES == 0) ? StRun : StWarmup;
          end else begin
            lfsr_d = shifted;
          end
        end
      end
      StWarmup: begin
        lfsr_d     = lfsr_step(lfsr_q);
        warm_cnt_d = warm_cnt_q + WARM_CNT_W'(1);
        if (warm_cnt_q == WARM_CNT_W'(WARM_LAST)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (valid_q && RandomReadySI) begin
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      default: state_d = StIdle;
    endcase

    // Reseed from any state; existing LFSR contents are shifted over, not cleared.
    if (SeedStartSI) begin
      state_d   = StLoad;
      bit_cnt_d = '0;
    end

    valid_d = (state_d == StRun);
    busy_d  = (state_d == StLoad) || (state_d == StWarmup);
  end

endmodule
